vx_cache_req_sched: RTL and testbench
=====================================

VX_CACHE_REQ_SCHED -- requirements
Module: VX_cache_req_sched

Interface
REQ-001 SHALL have parameters: NUM_REQS, 4, number of requesters (>=2); ADDR_WIDTH, 30, word address width; DATA_SIZE, 4, bytes per word; TAG_WIDTH, 8, requester tag width; MAX_PENDING, 4, outstanding reads per requester (>=1). Derived: LOG_NUM_REQS=clog2(NUM_REQS), DATA_WIDTH=8*DATA_SIZE, CNT_W=clog2(MAX_PENDING+1).
REQ-002 SHALL have ports: one clock and one reset; reset is asynchronous and active-high. Port list:
clk  in  1  clock
reset  in  1  asynchronous active-high reset
req_valid_in  in  NUM_REQS  per-requester request valid
req_rw_in  in  NUM_REQS  1=write, 0=read
req_addr_in  in  NUM_REQS*ADDR_WIDTH  address
req_byteen_in  in  NUM_REQS*DATA_SIZE  byte enables
req_data_in  in  NUM_REQS*DATA_WIDTH  write data
req_tag_in  in  NUM_REQS*TAG_WIDTH  requester tag
req_ready_in  out  NUM_REQS  request accepted
mem_req_valid / mem_req_rw / mem_req_addr / mem_req_byteen / mem_req_data  out  1/1/ADDR_WIDTH/DATA_SIZE/DATA_WIDTH  shared port request
mem_req_tag  out  TAG_WIDTH+LOG_NUM_REQS  {req tag, requester index in LSBs}
mem_req_ready  in  1  shared port ready
mem_rsp_valid / mem_rsp_data / mem_rsp_tag  in  1/DATA_WIDTH/TAG_WIDTH+LOG_NUM_REQS  shared port response
mem_rsp_ready  out  1  response accepted
rsp_valid_out / rsp_data_out / rsp_tag_out  out  NUM_REQS / NUM_REQS*DATA_WIDTH / NUM_REQS*TAG_WIDTH  routed response
rsp_ready_out  in  NUM_REQS  requester response ready
idle  out  1  no pending reads, output stage empty
err_unexpected_rsp  out  1  sticky: response for requester with zero pending

Function
REQ-003 SHALL select one eligible requester per cycle by round-robin; eligible = req_valid_in[i] && (req_rw_in[i] || pending[i] < MAX_PENDING).
REQ-004 SHALL hold the priority pointer unchanged unless a grant handshakes; on handshake of index g, pointer = (g+1) mod NUM_REQS.
REQ-005 SHALL register the granted request in a single output stage; stage_load = !stage_valid || mem_req_ready; req_ready_in[i] = stage_load && grant[i]; latency request->mem_req_valid exactly 1 cycle; throughput 1/cycle under continuous mem_req_ready.
REQ-006 SHALL keep mem_req_* stable while mem_req_valid && !mem_req_ready.
REQ-007 SHALL form mem_req_tag = {req_tag_in[g], g[LOG_NUM_REQS-1:0]}.
REQ-008 SHALL increment pending[g] on an accepted read, decrement pending[s] on a response handshake to requester s; simultaneous increment and decrement on same counter leaves it unchanged.
REQ-009 SHALL not consume credit for writes; writes never produce responses.
REQ-010 SHALL route responses combinationally: s = mem_rsp_tag[LOG_NUM_REQS-1:0]; rsp_valid_out[s] = mem_rsp_valid; rsp_tag_out[s] = mem_rsp_tag upper TAG_WIDTH bits; rsp_data_out broadcast; mem_rsp_ready = rsp_ready_out[s].
REQ-011 SHALL set err_unexpected_rsp on a response handshake when pending[s]==0, leave pending[s] at 0 (no wrap), and hold the flag until reset.
REQ-012 SHALL drive idle = !stage_valid && all pending==0.
REQ-013 SHALL give no grant and assert no req_ready_in when no requester is eligible.

Reset
REQ-014 SHALL on reset assertion immediately clear stage_valid, all pending counters, priority pointer (=0), err_unexpected_rsp; mem_req_valid=0, idle=1 during reset.
REQ-015 SHALL drop an in-flight staged request on reset mid-transfer; outstanding memory responses after reset are the environment's responsibility.

Structure
REQ-016 SHALL place LOG_NUM_REQS/CNT_W derivation helpers and the mem tag layout (index field position 0) in a shared package VX_cache_sched_pkg.
REQ-017 SHALL implement arbitration in one sub-module VX_rr_arbiter (request vector, enable, grant one-hot + index, pointer register).

Verification
REQ-018 SHALL cover: all 4 requesters read continuously, mem_req_ready=1 -> grants 0,1,2,3,0 on consecutive cycles, tags LSBs 0..3.
REQ-019 SHALL cover: requester 2 issues 5 reads, no responses, MAX_PENDING=4 -> 4 accepted, 5th stalls; one response to 2 -> 5th accepted next cycle.
REQ-020 SHALL cover: mem_req_ready=0 for 3 cycles with stage full -> mem_req_* unchanged, all req_ready_in=0; ready=1 -> stage drains, next grant loads same cycle.
REQ-021 SHALL cover: response tag {0x5A,2'd1}, rsp_ready_out[1]=0 -> rsp_valid_out=4'b0010, mem_rsp_ready=0; pending[1] unchanged until ready=1.
REQ-022 SHALL cover: response to requester 3 with pending[3]=0 -> err_unexpected_rsp=1 next cycle and sticky, pending[3] stays 0.
REQ-023 SHALL cover: reset asserted with stage full and pending[0]=2 -> mem_req_valid=0 and idle=1 without waiting for a clock edge.

Source files
------------

// File: rtl/vx_cache_req_sched_pkg.sv
// rtl/vx_cache_req_sched_pkg.sv - shared width helpers and memory tag layout for the request scheduler
package vx_cache_req_sched_pkg;

    // The requester index occupies the low bits of the memory-side tag.
    localparam int MEM_TAG_IDX_LSB = 0;

    // Index width for the requester field (at least one bit).
    function automatic int log2_reqs(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Counter width able to hold 0..max_pending inclusive.
    function automatic int cnt_width(input int max_pending);
        return $clog2(max_pending + 1);
    endfunction

endpackage

// File: rtl/vx_cache_req_sched_rr_arbiter.sv
// rtl/vx_cache_req_sched_rr_arbiter.sv - round-robin arbiter with pointer advancing only on a taken grant
module vx_cache_req_sched_rr_arbiter
    import vx_cache_req_sched_pkg::*;
#(
    parameter int NUM_REQS     = 4,
    parameter int LOG_NUM_REQS = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_REQS-1:0]     requests,
    input  logic                    enable,
    output logic [NUM_REQS-1:0]     grant_onehot,
    output logic [LOG_NUM_REQS-1:0] grant_index,
    output logic                    grant_valid
);

    logic [LOG_NUM_REQS-1:0] ptr;

    // Scan requesters starting at the pointer; first one found wins.
    always_comb begin
        int idx;
        idx          = 0;
        grant_onehot = '0;
        grant_index  = '0;
        grant_valid  = 1'b0;
        for (int k = 0; k < NUM_REQS; k++) begin
            idx = (int'(ptr) + k) % NUM_REQS;
            if (!grant_valid && requests[idx]) begin
                grant_valid       = 1'b1;
                grant_index       = LOG_NUM_REQS'(idx);
                grant_onehot[idx] = 1'b1;
            end
        end
    end

    // Move priority past the winner only when its request is actually taken.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr <= '0;
        end else if (enable && grant_valid) begin
            if (grant_index == LOG_NUM_REQS'(NUM_REQS - 1))
                ptr <= '0;
            else
                ptr <= grant_index + 1'b1;
        end
    end

endmodule

// File: rtl/vx_cache_req_sched.sv
// rtl/vx_cache_req_sched.sv - credit-limited round-robin request scheduler with routed responses
module vx_cache_req_sched
    import vx_cache_req_sched_pkg::*;
#(
    parameter int NUM_REQS    = 4,
    parameter int ADDR_WIDTH  = 30,
    parameter int DATA_SIZE   = 4,
    parameter int TAG_WIDTH   = 8,
    parameter int MAX_PENDING = 4,
    localparam int LOG_NUM_REQS = log2_reqs(NUM_REQS),
    localparam int DATA_WIDTH   = 8 * DATA_SIZE,
    localparam int CNT_W        = cnt_width(MAX_PENDING),
    localparam int MEM_TAG_W    = TAG_WIDTH + LOG_NUM_REQS
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [NUM_REQS-1:0]              req_valid_in,
    input  logic [NUM_REQS-1:0]              req_rw_in,
    input  logic [NUM_REQS*ADDR_WIDTH-1:0]   req_addr_in,
    input  logic [NUM_REQS*DATA_SIZE-1:0]    req_byteen_in,
    input  logic [NUM_REQS*DATA_WIDTH-1:0]   req_data_in,
    input  logic [NUM_REQS*TAG_WIDTH-1:0]    req_tag_in,
    output logic [NUM_REQS-1:0]              req_ready_in,
    output logic                             mem_req_valid,
    output logic                             mem_req_rw,
    output logic [ADDR_WIDTH-1:0]            mem_req_addr,
    output logic [DATA_SIZE-1:0]             mem_req_byteen,
    output logic [DATA_WIDTH-1:0]            mem_req_data,
    output logic [MEM_TAG_W-1:0]             mem_req_tag,
    input  logic                             mem_req_ready,
    input  logic                             mem_rsp_valid,
    input  logic [DATA_WIDTH-1:0]            mem_rsp_data,
    input  logic [MEM_TAG_W-1:0]             mem_rsp_tag,
    output logic                             mem_rsp_ready,
    output logic [NUM_REQS-1:0]              rsp_valid_out,
    output logic [NUM_REQS*DATA_WIDTH-1:0]   rsp_data_out,
    output logic [NUM_REQS*TAG_WIDTH-1:0]    rsp_tag_out,
    input  logic [NUM_REQS-1:0]              rsp_ready_out,
    output logic                             idle,
    output logic                             err_unexpected_rsp
);

    localparam logic [CNT_W-1:0] MAX_P = CNT_W'(MAX_PENDING);

    logic [CNT_W-1:0]        pending [NUM_REQS];
    logic [NUM_REQS-1:0]     eligible;
    logic [NUM_REQS-1:0]     grant_onehot;
    logic [LOG_NUM_REQS-1:0] grant_index;
    logic                    grant_valid;
    logic                    stage_valid;
    logic                    stage_load;
    logic                    accept;
    logic                    grant_rw;
    logic [LOG_NUM_REQS-1:0] rsp_sel;
    logic                    rsp_sel_ok;
    logic                    rsp_fire;
    logic                    rsp_unexpected;
    logic                    any_pending;
    logic [NUM_REQS-1:0]     inc;
    logic [NUM_REQS-1:0]     dec;

    // Writes bypass the credit check; reads need a free outstanding slot.
    always_comb begin
        eligible    = '0;
        any_pending = 1'b0;
        for (int i = 0; i < NUM_REQS; i++) begin
            eligible[i] = req_valid_in[i] && (req_rw_in[i] || (pending[i] < MAX_P));
            any_pending = any_pending || (pending[i] != '0);
        end
    end

    vx_cache_req_sched_rr_arbiter #(
        .NUM_REQS     (NUM_REQS),
        .LOG_NUM_REQS (LOG_NUM_REQS)
    ) u_arb (
        .clk          (clk),
        .reset        (reset),
        .requests     (eligible),
        .enable       (stage_load),
        .grant_onehot (grant_onehot),
        .grant_index  (grant_index),
        .grant_valid  (grant_valid)
    );

    assign stage_load   = !stage_valid || mem_req_ready;
    assign req_ready_in = stage_load ? grant_onehot : '0;
    assign accept       = stage_load && grant_valid;
    assign grant_rw     = req_rw_in[grant_index];

    // Single output register; holds its contents while the memory port stalls.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stage_valid    <= 1'b0;
            mem_req_rw     <= 1'b0;
            mem_req_addr   <= '0;
            mem_req_byteen <= '0;
            mem_req_data   <= '0;
            mem_req_tag    <= '0;
        end else if (stage_load) begin
            stage_valid <= grant_valid;
            if (grant_valid) begin
                mem_req_rw     <= grant_rw;
                mem_req_addr   <= req_addr_in[int'(grant_index)*ADDR_WIDTH +: ADDR_WIDTH];
                mem_req_byteen <= req_byteen_in[int'(grant_index)*DATA_SIZE +: DATA_SIZE];
                mem_req_data   <= req_data_in[int'(grant_index)*DATA_WIDTH +: DATA_WIDTH];
                mem_req_tag    <= {req_tag_in[int'(grant_index)*TAG_WIDTH +: TAG_WIDTH], grant_index};
            end
        end
    end

    assign mem_req_valid = stage_valid;

    // Response steering by the requester index carried in the tag.
    assign rsp_sel        = mem_rsp_tag[MEM_TAG_IDX_LSB +: LOG_NUM_REQS];
    assign rsp_sel_ok     = int'(rsp_sel) < NUM_REQS;
    assign mem_rsp_ready  = rsp_sel_ok && rsp_ready_out[rsp_sel];
    assign rsp_fire       = mem_rsp_valid && mem_rsp_ready;
    assign rsp_unexpected = rsp_fire && (pending[rsp_sel] == '0);
    assign rsp_data_out   = {NUM_REQS{mem_rsp_data}};
    assign rsp_tag_out    = {NUM_REQS{mem_rsp_tag[MEM_TAG_W-1 -: TAG_WIDTH]}};

    // Per-requester valid plus credit increment/decrement strobes.
    always_comb begin
        rsp_valid_out = '0;
        inc           = '0;
        dec           = '0;
        for (int i = 0; i < NUM_REQS; i++) begin
            rsp_valid_out[i] = mem_rsp_valid && (rsp_sel == LOG_NUM_REQS'(i));
            inc[i] = accept && !grant_rw && (grant_index == LOG_NUM_REQS'(i));
            dec[i] = rsp_fire && (rsp_sel == LOG_NUM_REQS'(i));
        end
    end

    // Outstanding-read counters; a decrement at zero is absorbed rather than wrapping.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_REQS; i++) pending[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_REQS; i++) begin
                if (inc[i] && !dec[i])
                    pending[i] <= pending[i] + 1'b1;
                else if (dec[i] && !inc[i] && (pending[i] != '0))
                    pending[i] <= pending[i] - 1'b1;
            end
        end
    end

    // Sticky flag for responses nobody was waiting on.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            err_unexpected_rsp <= 1'b0;
        else if (rsp_unexpected)
            err_unexpected_rsp <= 1'b1;
    end

    assign idle = !stage_valid && !any_pending;

endmodule

// File: tb/tb_vx_cache_req_sched.sv
// tb/tb_vx_cache_req_sched.sv - directed self-checking bench for the cache request scheduler
module tb_vx_cache_req_sched;

    localparam int N  = 4;
    localparam int AW = 30;
    localparam int DS = 4;
    localparam int DW = 32;
    localparam int TW = 8;
    localparam int MW = TW + 2;

    logic            clk = 1'b0;
    logic            reset;
    logic [N-1:0]    req_valid_in;
    logic [N-1:0]    req_rw_in;
    logic [N*AW-1:0] req_addr_in;
    logic [N*DS-1:0] req_byteen_in;
    logic [N*DW-1:0] req_data_in;
    logic [N*TW-1:0] req_tag_in;
    logic [N-1:0]    req_ready_in;
    logic            mem_req_valid;
    logic            mem_req_rw;
    logic [AW-1:0]   mem_req_addr;
    logic [DS-1:0]   mem_req_byteen;
    logic [DW-1:0]   mem_req_data;
    logic [MW-1:0]   mem_req_tag;
    logic            mem_req_ready;
    logic            mem_rsp_valid;
    logic [DW-1:0]   mem_rsp_data;
    logic [MW-1:0]   mem_rsp_tag;
    logic            mem_rsp_ready;
    logic [N-1:0]    rsp_valid_out;
    logic [N*DW-1:0] rsp_data_out;
    logic [N*TW-1:0] rsp_tag_out;
    logic [N-1:0]    rsp_ready_out;
    logic            idle;
    logic            err_unexpected_rsp;

    int checks = 0;
    int errors = 0;

    vx_cache_req_sched #(
        .NUM_REQS(N), .ADDR_WIDTH(AW), .DATA_SIZE(DS), .TAG_WIDTH(TW), .MAX_PENDING(4)
    ) dut (
        .clk(clk), .reset(reset),
        .req_valid_in(req_valid_in), .req_rw_in(req_rw_in), .req_addr_in(req_addr_in),
        .req_byteen_in(req_byteen_in), .req_data_in(req_data_in), .req_tag_in(req_tag_in),
        .req_ready_in(req_ready_in),
        .mem_req_valid(mem_req_valid), .mem_req_rw(mem_req_rw), .mem_req_addr(mem_req_addr),
        .mem_req_byteen(mem_req_byteen), .mem_req_data(mem_req_data), .mem_req_tag(mem_req_tag),
        .mem_req_ready(mem_req_ready),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data), .mem_rsp_tag(mem_rsp_tag),
        .mem_rsp_ready(mem_rsp_ready),
        .rsp_valid_out(rsp_valid_out), .rsp_data_out(rsp_data_out), .rsp_tag_out(rsp_tag_out),
        .rsp_ready_out(rsp_ready_out),
        .idle(idle), .err_unexpected_rsp(err_unexpected_rsp)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic v, input logic rw, input logic [AW-1:0] a,
                           input logic [TW-1:0] t, input logic [DW-1:0] d, input logic [DS-1:0] be);
        req_valid_in[i]           = v;
        req_rw_in[i]              = rw;
        req_addr_in[i*AW +: AW]   = a;
        req_tag_in[i*TW +: TW]    = t;
        req_data_in[i*DW +: DW]   = d;
        req_byteen_in[i*DS +: DS] = be;
    endtask

    task automatic clear_inputs();
        req_valid_in  = '0;
        req_rw_in     = '0;
        req_addr_in   = '0;
        req_byteen_in = '0;
        req_data_in   = '0;
        req_tag_in    = '0;
        mem_req_ready = 1'b1;
        mem_rsp_valid = 1'b0;
        mem_rsp_data  = '0;
        mem_rsp_tag   = '0;
        rsp_ready_out = '1;
    endtask

    task automatic do_reset();
        clear_inputs();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        #1;
    endtask

    initial begin
        clear_inputs();
        reset = 1'b1;
        #3;
        check("rst_mem_req_valid", 64'(mem_req_valid), 64'd0);
        check("rst_idle", 64'(idle), 64'd1);
        check("rst_err", 64'(err_unexpected_rsp), 64'd0);
        check("rst_req_ready", 64'(req_ready_in), 64'd0);
        do_reset();

        // All four read continuously: grants rotate 0,1,2,3,0
        for (int i = 0; i < N; i++)
            set_req(i, 1'b1, 1'b0, AW'(100 + i), TW'(8'h10 + i), DW'(0), 4'hF);
        #1;
        for (int k = 0; k < 5; k++) begin
            check($sformatf("rr_ready_%0d", k), 64'(req_ready_in), 64'(4'b0001 << (k % 4)));
            tick();
            check($sformatf("rr_valid_%0d", k), 64'(mem_req_valid), 64'd1);
            check($sformatf("rr_tag_%0d", k), 64'(mem_req_tag),
                  64'({8'h10 + 8'(k % 4), 2'(k % 4)}));
            check($sformatf("rr_addr_%0d", k), 64'(mem_req_addr), 64'(100 + (k % 4)));
        end
        req_valid_in = '0;
        tick();
        check("rr_drain_valid", 64'(mem_req_valid), 64'd0);
        check("rr_idle_pending", 64'(idle), 64'd0);

        // Credit limit on requester 2
        do_reset();
        set_req(2, 1'b1, 1'b0, AW'(200), TW'(8'h22), DW'(0), 4'hF);
        #1;
        for (int k = 0; k < 4; k++) begin
            check($sformatf("cred_ready_%0d", k), 64'(req_ready_in), 64'b0100);
            tick();
        end
        check("cred_stall_ready", 64'(req_ready_in), 64'd0);
        tick();
        check("cred_stall_ready2", 64'(req_ready_in), 64'd0);
        check("cred_stall_valid", 64'(mem_req_valid), 64'd0);
        mem_rsp_valid = 1'b1;
        mem_rsp_tag   = {8'h33, 2'd2};
        mem_rsp_data  = 32'hCAFE_0002;
        #1;
        check("cred_rsp_valid", 64'(rsp_valid_out), 64'b0100);
        check("cred_rsp_ready", 64'(mem_rsp_ready), 64'd1);
        check("cred_still_stalled", 64'(req_ready_in), 64'd0);
        tick();
        mem_rsp_valid = 1'b0;
        #1;
        check("cred_fifth_ready", 64'(req_ready_in), 64'b0100);
        tick();
        check("cred_fifth_valid", 64'(mem_req_valid), 64'd1);
        check("cred_fifth_tag", 64'(mem_req_tag), 64'({8'h22, 2'd2}));
        check("cred_full_again", 64'(req_ready_in), 64'd0);

        // Backpressure with a full stage
        do_reset();
        mem_req_ready = 1'b0;
        set_req(1, 1'b1, 1'b0, AW'(30'h111), TW'(8'hA1), DW'(32'h0), 4'hF);
        set_req(3, 1'b1, 1'b1, AW'(30'h333), TW'(8'hA3), DW'(32'hDEAD_BEEF), 4'h6);
        #1;
        check("bp_first_ready", 64'(req_ready_in), 64'b0010);
        tick();
        req_valid_in[1] = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            check($sformatf("bp_ready_%0d", k), 64'(req_ready_in), 64'd0);
            check($sformatf("bp_valid_%0d", k), 64'(mem_req_valid), 64'd1);
            check($sformatf("bp_addr_%0d", k), 64'(mem_req_addr), 64'h111);
            check($sformatf("bp_tag_%0d", k), 64'(mem_req_tag), 64'({8'hA1, 2'd1}));
            tick();
        end
        mem_req_ready = 1'b1;
        #1;
        check("bp_release_ready", 64'(req_ready_in), 64'b1000);
        tick();
        req_valid_in[3] = 1'b0;
        check("bp_w_rw", 64'(mem_req_rw), 64'd1);
        check("bp_w_addr", 64'(mem_req_addr), 64'h333);
        check("bp_w_data", 64'(mem_req_data), 64'hDEAD_BEEF);
        check("bp_w_byteen", 64'(mem_req_byteen), 64'h6);
        check("bp_w_tag", 64'(mem_req_tag), 64'({8'hA3, 2'd3}));
        tick();
        check("bp_drained", 64'(mem_req_valid), 64'd0);
        check("bp_not_idle", 64'(idle), 64'd0);

        // Response to requester 1 held off by its ready
        mem_rsp_valid = 1'b1;
        mem_rsp_tag   = {8'h5A, 2'd1};
        mem_rsp_data  = 32'h1234_5678;
        rsp_ready_out = 4'b1101;
        #1;
        check("rsp_valid_vec", 64'(rsp_valid_out), 64'b0010);
        check("rsp_mem_ready_lo", 64'(mem_rsp_ready), 64'd0);
        check("rsp_tag1", 64'(rsp_tag_out[1*TW +: TW]), 64'h5A);
        check("rsp_data1", 64'(rsp_data_out[1*DW +: DW]), 64'h1234_5678);
        tick();
        check("rsp_hold_not_idle", 64'(idle), 64'd0);
        rsp_ready_out = 4'b1111;
        #1;
        check("rsp_mem_ready_hi", 64'(mem_rsp_ready), 64'd1);
        tick();
        mem_rsp_valid = 1'b0;
        #1;
        check("rsp_idle_after", 64'(idle), 64'd1);
        check("rsp_no_err", 64'(err_unexpected_rsp), 64'd0);

        // Unexpected response to requester 3
        mem_rsp_valid = 1'b1;
        mem_rsp_tag   = {8'h77, 2'd3};
        tick();
        mem_rsp_valid = 1'b0;
        #1;
        check("unexp_err_set", 64'(err_unexpected_rsp), 64'd1);
        check("unexp_no_wrap", 64'(idle), 64'd1);
        tick();
        tick();
        check("unexp_err_sticky", 64'(err_unexpected_rsp), 64'd1);

        // Asynchronous reset with a full stage and two reads outstanding
        set_req(0, 1'b1, 1'b0, AW'(30'h50), TW'(8'h01), DW'(0), 4'hF);
        tick();
        tick();
        req_valid_in  = '0;
        mem_req_ready = 1'b0;
        #1;
        check("ar_pre_valid", 64'(mem_req_valid), 64'd1);
        check("ar_pre_idle", 64'(idle), 64'd0);
        #1;
        reset = 1'b1;
        #1;
        check("ar_valid_cleared", 64'(mem_req_valid), 64'd0);
        check("ar_idle", 64'(idle), 64'd1);
        check("ar_err_cleared", 64'(err_unexpected_rsp), 64'd0);
        tick();
        reset = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
